te_dark_channel_pipe: RTL and testbench

- Pipelined stage directly downstream of the per-pixel minimum-channel comparator in the transmission-estimation (TE) path.
- Accepts an RGB pixel plus the comparator's 2-bit channel select, muxes out the dark-channel value and computes the clamped transmission estimate t = max(255 - ((OMEGA*dark)>>8), T_MIN).
- Two register stages, valid/ready handshake on both sides, and raster position tracking that tags each output beat with end-of-line and end-of-frame.

---
 rtl/te_dark_channel_pipe.sv | 107 ++++++++++
 tb/tb_te_dark_channel_pipe.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/te_dark_channel_pipe.sv
// Transmission-estimation stage: muxes the dark-channel value selected by the comparator
// and derives the clamped transmission t = max(255 - (OMEGA*dark)>>8, T_MIN) over two register stages.
module te_dark_channel_pipe #(
  parameter int OMEGA      = 243,
  parameter int T_MIN      = 26,
  parameter int IMG_WIDTH  = 512,
  parameter int IMG_HEIGHT = 512
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] red,
  input  logic [7:0] green,
  input  logic [7:0] blue,
  input  logic [1:0] min_sel,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] dark,
  output logic [7:0] trans,
  output logic       out_eol,
  output logic       out_eof
);

  localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [7:0]    OMEGA_Q  = 8'(OMEGA);
  localparam logic [7:0]    T_MIN_Q  = 8'(T_MIN);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  logic          en;
  logic          out_fire;
  logic          s1_valid;
  logic          s2_valid;
  logic [7:0]    s1_dark;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          last_col;
  logic          last_row;

  // Code 11 from the comparator is folded onto BLUE.
  function automatic logic [7:0] select_dark(input logic [7:0] r, input logic [7:0] g,
                                             input logic [7:0] b, input logic [1:0] sel);
    logic [7:0] v;
    case (sel)
      2'b00:   v = r;
      2'b01:   v = g;
      default: v = b;
    endcase
    return v;
  endfunction

  function automatic logic [7:0] calc_trans(input logic [7:0] d);
    logic [15:0] prod;
    logic [7:0]  raw;
    prod = {8'h00, OMEGA_Q} * {8'h00, d};
    raw  = 8'hFF - prod[15:8];
    return (raw < T_MIN_Q) ? T_MIN_Q : raw;
  endfunction

  // A stalled output freezes the whole pipe, even when s1 is empty.
  assign en        = out_ready | ~s2_valid;
  assign in_ready  = en;
  assign out_valid = s2_valid;
  assign out_fire  = s2_valid & out_ready;
  assign last_col  = (col == COL_LAST);
  assign last_row  = (row == ROW_LAST);
  assign out_eol   = s2_valid & last_col;
  assign out_eof   = out_eol & last_row;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_dark  <= 8'h00;
      s2_valid <= 1'b0;
      dark     <= 8'h00;
      trans    <= 8'h00;
    end else if (en) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_dark <= select_dark(red, green, blue, min_sel);
      end
      s2_valid <= s1_valid;
      if (s1_valid) begin
        dark  <= s1_dark;
        trans <= calc_trans(s1_dark);
      end
    end
  end

  // Raster position of the beat currently presented at the output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (out_fire) begin
      if (last_col) begin
        col <= '0;
        row <= last_row ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_te_dark_channel_pipe.sv
// Randomized and directed bench for te_dark_channel_pipe on a 4x2 frame, checked against a
// queue-based reference model of the dark-channel / transmission arithmetic and raster framing.
module tb_te_dark_channel_pipe;

  localparam int OMEGA = 243;
  localparam int T_MIN = 26;
  localparam int W     = 4;
  localparam int H     = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] red = 8'h00, green = 8'h00, blue = 8'h00;
  logic [1:0] min_sel = 2'b00;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] dark, trans;
  logic       out_eol, out_eof;

  te_dark_channel_pipe #(.OMEGA(OMEGA), .T_MIN(T_MIN), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .red(red), .green(green), .blue(blue), .min_sel(min_sel),
    .out_valid(out_valid), .out_ready(out_ready), .dark(dark), .trans(trans),
    .out_eol(out_eol), .out_eof(out_eof)
  );

  always #5 clk = ~clk;

  typedef struct {
    int d;
    int t;
  } exp_t;

  exp_t exp_q[$];
  int   pass_cnt  = 0;
  int   total     = 0;
  int   out_beats = 0;
  logic held = 1'b0;
  logic last_ov = 1'b0;
  logic [7:0] h_dark, h_trans;
  logic h_eol, h_eof;

  function automatic int ref_dark(int r, int g, int b, int s);
    if (s == 0) return r;
    if (s == 1) return g;
    return b;
  endfunction

  function automatic int ref_trans(int d);
    int t;
    t = 255 - (OMEGA * d) / 256;
    return (t < T_MIN) ? T_MIN : t;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // One clock: drive inputs, observe at the falling edge, score handshakes, return past the rising edge.
  task automatic cycle(input logic iv, input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                       input logic [1:0] s, input logic ordy, output logic acc);
    exp_t e;
    in_valid = iv; red = r; green = g; blue = b; min_sel = s; out_ready = ordy;
    @(negedge clk);
    last_ov = out_valid;
    if (held) begin
      check("hold_valid", out_valid, 1);
      check("hold_dark", dark, h_dark);
      check("hold_trans", trans, h_trans);
      check("hold_eol", out_eol, h_eol);
      check("hold_eof", out_eof, h_eof);
    end
    held = out_valid && !out_ready;
    if (held) begin
      check("stall_in_ready", in_ready, 0);
      h_dark = dark; h_trans = trans; h_eol = out_eol; h_eof = out_eof;
    end
    if (!out_valid) begin
      check("idle_eol", out_eol, 0);
      check("idle_eof", out_eof, 0);
    end
    if (out_valid && out_ready) begin
      check("beat_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("dark", dark, e.d);
        check("trans", trans, e.t);
        check("eol", out_eol, 32'((out_beats % W) == W - 1));
        check("eof", out_eof, 32'((out_beats % (W * H)) == W * H - 1));
        out_beats++;
      end
    end
    acc = iv && in_ready;
    if (acc) begin
      e.d = ref_dark(r, g, b, s);
      e.t = ref_trans(e.d);
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  // Hold one pixel on the input until it is taken, with a random stall percentage downstream.
  task automatic send(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                      input logic [1:0] s, input int stall_pct);
    logic acc;
    acc = 1'b0;
    for (int i = 0; i < 40 && !acc; i++) begin
      cycle(1'b1, r, g, b, s, 1'($urandom_range(0, 99) >= stall_pct), acc);
    end
    check("send_accepted", acc, 1);
  endtask

  task automatic drain();
    logic acc;
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) begin
      cycle(1'b0, 8'h00, 8'h00, 8'h00, 2'b00, 1'b1, acc);
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_dark", dark, 0);
    check("rst_trans", trans, 0);
    check("rst_eol", out_eol, 0);
    check("rst_eof", out_eof, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    out_beats = 0;
    held = 1'b0;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_idle_valid", out_valid, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic acc;
    logic [7:0] pr, pg, pb;
    logic [1:0] ps;

    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Two-cycle latency on the first pixel.
    cycle(1'b1, 8'd100, 8'd180, 8'd200, 2'b00, 1'b1, acc);
    check("lat_accept", acc, 1);
    cycle(1'b0, 8'h00, 8'h00, 8'h00, 2'b00, 1'b1, acc);
    check("lat_s1", last_ov, 0);
    cycle(1'b0, 8'h00, 8'h00, 8'h00, 2'b00, 1'b1, acc);
    check("lat_s2", last_ov, 1);

    // Directed values at full rate: zero dark, clamp with sel=11, comparator tie.
    send(8'd10, 8'd255, 8'd0, 2'b10, 0);
    send(8'd255, 8'd255, 8'd255, 2'b11, 0);
    send(8'd50, 8'd50, 8'd80, 2'b00, 0);
    send(8'd7, 8'd128, 8'd9, 2'b01, 0);
    drain();

    // Backpressure: five stalled cycles while the input keeps presenting data.
    pr = 8'($urandom); pg = 8'($urandom); pb = 8'($urandom); ps = 2'($urandom);
    for (int i = 0; i < 14; i++) begin
      cycle(1'b1, pr, pg, pb, ps, 1'(!(i >= 3 && i < 8)), acc);
      if (acc) begin
        pr = 8'($urandom); pg = 8'($urandom); pb = 8'($urandom); ps = 2'($urandom);
      end
    end
    drain();

    // Framing from a clean frame start: 9 pixels with random gaps and stalls.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      if ($urandom_range(0, 2) == 0) cycle(1'b0, 8'h00, 8'h00, 8'h00, 2'b00, 1'($urandom), acc);
      send(8'($urandom), 8'($urandom), 8'($urandom), 2'($urandom), 30);
    end
    drain();
    check("frame_beats", out_beats, 9);

    // Longer random run spanning several frames.
    for (int i = 0; i < 40; i++) begin
      send(8'($urandom), 8'($urandom), 8'($urandom), 2'($urandom), 25);
    end
    drain();

    // Reset mid-line with pixels in flight; the next beat must be column 0, row 0.
    for (int i = 0; i < 30 && out_beats % W != 3; i++) begin
      cycle(1'b1, 8'($urandom), 8'($urandom), 8'($urandom), 2'($urandom), 1'b1, acc);
    end
    check("pre_reset_col", out_beats % W, 3);
    do_reset();
    for (int i = 0; i < 5; i++) begin
      send(8'($urandom), 8'($urandom), 8'($urandom), 2'($urandom), 20);
    end
    drain();

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
